// File: rtl/ps2_scan_parser_pkg.sv
// Shared constants for the PS/2 scan-code parser: protocol prefixes, Shift make codes, FSM states.
package ps2_scan_parser_pkg;

  localparam logic [7:0] PS2_EXT_CODE = 8'hE0;
  localparam logic [7:0] PS2_BRK_CODE = 8'hF0;
  localparam logic [7:0] SHIFT_L_CODE = 8'h12;
  localparam logic [7:0] SHIFT_R_CODE = 8'h59;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_POP  = 2'd1,
    ST_GAP  = 2'd2
  } ps2_state_t;

  function automatic logic is_prefix(input logic [7:0] b);
    return (b == PS2_EXT_CODE) || (b == PS2_BRK_CODE);
  endfunction

endpackage

// File: rtl/ps2_scan_parser_if.sv
// Receiver-FIFO read port: the FIFO (master) presents bytes, the parser (slave) pops them.
interface ps2_scan_parser_if;
  logic       ps2_ready;
  logic [7:0] ps2_data;
  logic       ps2_overflow;
  logic       ps2_nextdata_n;

  modport master (output ps2_ready, output ps2_data, output ps2_overflow, input ps2_nextdata_n);
  modport slave  (input ps2_ready, input ps2_data, input ps2_overflow, output ps2_nextdata_n);
endinterface

// File: rtl/ps2_scan_parser.sv
// Pops PS/2 bytes, strips E0/F0 prefixes, tracks Shift, suppresses typematic repeats and
// presents held-key level, new-key strobe, make code and press count to the ASCII decoder.
module ps2_scan_parser
  import ps2_scan_parser_pkg::*;
#(
  parameter int         CNT_W   = 8,
  parameter logic [7:0] SHIFT_L = SHIFT_L_CODE,
  parameter logic [7:0] SHIFT_R = SHIFT_R_CODE
) (
  input  logic              clk,
  input  logic              clrn,
  ps2_scan_parser_if.slave  fifo,
  output logic              key_ready,
  output logic              key_strobe_n,
  output logic [7:0]        scan_code,
  output logic              key_ext,
  output logic              combination,
  output logic [CNT_W-1:0]  key_count
);

  ps2_state_t state;
  logic [7:0] byte_r;
  logic       nextdata_n;
  logic       ext_f;
  logic       brk_f;
  logic       shift_l;
  logic       shift_r;
  logic       is_shift_l;
  logic       is_shift_r;
  logic       is_held;

  assign fifo.ps2_nextdata_n = nextdata_n;

  // Extended Shift codes (E0 12 / E0 59) are ordinary keys, not modifiers.
  assign is_shift_l = !ext_f && (byte_r == SHIFT_L);
  assign is_shift_r = !ext_f && (byte_r == SHIFT_R);
  assign is_held    = (byte_r == scan_code) && (ext_f == key_ext);

  // Byte capture: data only, qualified by the IDLE-state pop decision.
  always_ff @(posedge clk) begin
    if (state == ST_IDLE && fifo.ps2_ready) byte_r <= fifo.ps2_data;
  end

  // Control FSM: IDLE latches a byte, POP strobes the FIFO and classifies, GAP lets the FIFO settle.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state        <= ST_IDLE;
      nextdata_n   <= 1'b1;
      key_strobe_n <= 1'b1;
      key_ready    <= 1'b0;
      scan_code    <= 8'h00;
      key_ext      <= 1'b0;
      combination  <= 1'b0;
      key_count    <= '0;
      ext_f        <= 1'b0;
      brk_f        <= 1'b0;
      shift_l      <= 1'b0;
      shift_r      <= 1'b0;
    end else begin
      key_strobe_n <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (fifo.ps2_overflow) begin
            ext_f <= 1'b0;
            brk_f <= 1'b0;
          end
          if (fifo.ps2_ready) begin
            state      <= ST_POP;
            nextdata_n <= 1'b0;
          end
        end
        ST_POP: begin
          nextdata_n <= 1'b1;
          state      <= ST_GAP;
          if (is_prefix(byte_r)) begin
            if (byte_r == PS2_EXT_CODE) ext_f <= 1'b1;
            else                        brk_f <= 1'b1;
          end else begin
            ext_f <= 1'b0;
            brk_f <= 1'b0;
            if (!brk_f) begin
              if (is_shift_l) begin
                shift_l     <= 1'b1;
                combination <= 1'b1;
              end else if (is_shift_r) begin
                shift_r     <= 1'b1;
                combination <= 1'b1;
              end else if (!(key_ready && is_held)) begin
                // Genuine new press; last pressed key replaces any held one.
                scan_code    <= byte_r;
                key_ext      <= ext_f;
                key_ready    <= 1'b1;
                key_strobe_n <= 1'b0;
                key_count    <= key_count + CNT_W'(1);
              end
            end else begin
              if (is_shift_l) begin
                shift_l     <= 1'b0;
                combination <= shift_r;
              end else if (is_shift_r) begin
                shift_r     <= 1'b0;
                combination <= shift_l;
              end else if (is_held) begin
                key_ready <= 1'b0;
              end
            end
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
